// File: rtl/rs_pkg.sv
// Shared types and sizing for the reservation station and its entry slots.
// src_wake holds the dual-CDB tag match used at dispatch and while an entry waits.
package rs_pkg;

  localparam int NUM_RS = 8;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int IDX_W  = 3;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              rdy;
    logic [DATA_W-1:0] val;
  } rs_src_t;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dst;
    rs_src_t          s1;
    rs_src_t          s2;
  } rs_ent_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dst;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } rs_iss_t;

  // CDB lane 0 wins when both lanes broadcast the same tag.
  function automatic rs_src_t src_wake(
    input rs_src_t           src,
    input logic              v0,
    input logic [TAG_W-1:0]  t0,
    input logic [DATA_W-1:0] d0,
    input logic              v1,
    input logic [TAG_W-1:0]  t1,
    input logic [DATA_W-1:0] d1
  );
    rs_src_t r;
    r = src;
    if (!src.rdy) begin
      if (v0 && (src.tag == t0)) begin
        r.rdy = 1'b1;
        r.val = d0;
      end else if (v1 && (src.tag == t1)) begin
        r.rdy = 1'b1;
        r.val = d1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_slot.sv
// One reservation-station entry: dispatch write port, dual-CDB operand
// capture while busy, and busy clear when the entry is issued.
module rs_slot import rs_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  rs_ent_t           wr_ent,
  input  logic              clr,
  input  logic              cdb_valid0,
  input  logic [TAG_W-1:0]  cdb_tag0,
  input  logic [DATA_W-1:0] cdb_val0,
  input  logic              cdb_valid1,
  input  logic [TAG_W-1:0]  cdb_tag1,
  input  logic [DATA_W-1:0] cdb_val1,
  output rs_ent_t           ent
);

  rs_ent_t ent_d;
  rs_ent_t ent_q;

  // Write and clear never hit the same slot: a free slot is never ready.
  always_comb begin
    ent_d = ent_q;
    if (ent_q.busy) begin
      ent_d.s1 = src_wake(ent_q.s1, cdb_valid0, cdb_tag0, cdb_val0,
                          cdb_valid1, cdb_tag1, cdb_val1);
      ent_d.s2 = src_wake(ent_q.s2, cdb_valid0, cdb_tag0, cdb_val0,
                          cdb_valid1, cdb_tag1, cdb_val1);
    end
    if (clr) begin
      ent_d.busy = 1'b0;
    end
    if (wr_en) begin
      ent_d      = wr_ent;
      ent_d.busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign ent = ent_q;

endmodule

// File: rtl/reservation_station.sv
// Eight-entry reservation station: dispatch decode into slots chosen by the
// external allocator, popcount-qualified dual issue into registered FU ports.
module reservation_station import rs_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_valid0,
  input  logic [OP_W-1:0]   disp_op0,
  input  logic [TAG_W-1:0]  disp_dst0,
  input  logic [TAG_W-1:0]  disp_s1_tag0,
  input  logic [TAG_W-1:0]  disp_s2_tag0,
  input  logic              disp_s1_rdy0,
  input  logic              disp_s2_rdy0,
  input  logic [DATA_W-1:0] disp_s1_val0,
  input  logic [DATA_W-1:0] disp_s2_val0,
  input  logic              disp_valid1,
  input  logic [OP_W-1:0]   disp_op1,
  input  logic [TAG_W-1:0]  disp_dst1,
  input  logic [TAG_W-1:0]  disp_s1_tag1,
  input  logic [TAG_W-1:0]  disp_s2_tag1,
  input  logic              disp_s1_rdy1,
  input  logic              disp_s2_rdy1,
  input  logic [DATA_W-1:0] disp_s1_val1,
  input  logic [DATA_W-1:0] disp_s2_val1,
  output logic              disp_ready,
  input  logic [2:0]        rs_entry0,
  input  logic [2:0]        rs_entry1,
  input  logic [2:0]        rs_issue0,
  input  logic [2:0]        rs_issue1,
  input  logic              rs_full,
  output logic [0:7]        free_rs,
  output logic [0:7]        rdy,
  input  logic              cdb_valid0,
  input  logic [TAG_W-1:0]  cdb_tag0,
  input  logic [DATA_W-1:0] cdb_val0,
  input  logic              cdb_valid1,
  input  logic [TAG_W-1:0]  cdb_tag1,
  input  logic [DATA_W-1:0] cdb_val1,
  input  logic              fu_ready0,
  input  logic              fu_ready1,
  output logic              iss_valid0,
  output logic [OP_W-1:0]   iss_op0,
  output logic [TAG_W-1:0]  iss_dst0,
  output logic [DATA_W-1:0] iss_a0,
  output logic [DATA_W-1:0] iss_b0,
  output logic              iss_valid1,
  output logic [OP_W-1:0]   iss_op1,
  output logic [TAG_W-1:0]  iss_dst1,
  output logic [DATA_W-1:0] iss_a1,
  output logic [DATA_W-1:0] iss_b1
);

  rs_ent_t           ent    [NUM_RS];
  rs_ent_t           wr_ent [NUM_RS];
  logic [NUM_RS-1:0] wr_en;
  logic [NUM_RS-1:0] clr;
  rs_ent_t           disp_ent0;
  rs_ent_t           disp_ent1;
  logic              accept0;
  logic              accept1;
  logic [3:0]        n_rdy;
  logic              fire0;
  logic              fire1;
  rs_iss_t           iss0_d, iss0_q;
  rs_iss_t           iss1_d, iss1_q;

  assign disp_ready = ~rs_full;
  assign accept0    = disp_ready & disp_valid0;
  assign accept1    = disp_ready & disp_valid1;

  // A source missing at dispatch can still be caught by this cycle's broadcast.
  always_comb begin
    disp_ent0      = '0;
    disp_ent0.busy = 1'b1;
    disp_ent0.op   = disp_op0;
    disp_ent0.dst  = disp_dst0;
    disp_ent0.s1   = src_wake('{tag: disp_s1_tag0, rdy: disp_s1_rdy0, val: disp_s1_val0},
                              cdb_valid0, cdb_tag0, cdb_val0, cdb_valid1, cdb_tag1, cdb_val1);
    disp_ent0.s2   = src_wake('{tag: disp_s2_tag0, rdy: disp_s2_rdy0, val: disp_s2_val0},
                              cdb_valid0, cdb_tag0, cdb_val0, cdb_valid1, cdb_tag1, cdb_val1);
    disp_ent1      = '0;
    disp_ent1.busy = 1'b1;
    disp_ent1.op   = disp_op1;
    disp_ent1.dst  = disp_dst1;
    disp_ent1.s1   = src_wake('{tag: disp_s1_tag1, rdy: disp_s1_rdy1, val: disp_s1_val1},
                              cdb_valid0, cdb_tag0, cdb_val0, cdb_valid1, cdb_tag1, cdb_val1);
    disp_ent1.s2   = src_wake('{tag: disp_s2_tag1, rdy: disp_s2_rdy1, val: disp_s2_val1},
                              cdb_valid0, cdb_tag0, cdb_val0, cdb_valid1, cdb_tag1, cdb_val1);
  end

  always_comb begin
    for (int j = 0; j < NUM_RS; j++) begin
      free_rs[j] = ~ent[j].busy;
      rdy[j]     = ent[j].busy & ent[j].s1.rdy & ent[j].s2.rdy;
    end
  end

  always_comb begin
    n_rdy = '0;
    for (int j = 0; j < NUM_RS; j++) begin
      n_rdy = n_rdy + {3'b000, rdy[j]};
    end
  end

  // Allocator issue indices are undriven when it has no slot; use them only when qualified.
  assign fire0 = (n_rdy >= 4'd1) & fu_ready0;
  assign fire1 = (n_rdy >= 4'd2) & fu_ready1;

  always_comb begin
    for (int j = 0; j < NUM_RS; j++) begin
      wr_en[j]  = (accept0 && (rs_entry0 == IDX_W'(j))) ||
                  (accept1 && (rs_entry1 == IDX_W'(j)));
      wr_ent[j] = (accept0 && (rs_entry0 == IDX_W'(j))) ? disp_ent0 : disp_ent1;
      clr[j]    = (fire0 && (rs_issue0 == IDX_W'(j))) ||
                  (fire1 && (rs_issue1 == IDX_W'(j)));
    end
  end

  for (genvar g = 0; g < NUM_RS; g++) begin : g_slot
    rs_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en[g]),
      .wr_ent     (wr_ent[g]),
      .clr        (clr[g]),
      .cdb_valid0 (cdb_valid0),
      .cdb_tag0   (cdb_tag0),
      .cdb_val0   (cdb_val0),
      .cdb_valid1 (cdb_valid1),
      .cdb_tag1   (cdb_tag1),
      .cdb_val1   (cdb_val1),
      .ent        (ent[g])
    );
  end

  // A stalled FU keeps its issue register; an idle-but-ready FU drops valid.
  always_comb begin
    iss0_d = iss0_q;
    if (fire0) begin
      iss0_d = '{valid: 1'b1, op: ent[rs_issue0].op, dst: ent[rs_issue0].dst,
                 a: ent[rs_issue0].s1.val, b: ent[rs_issue0].s2.val};
    end else if (fu_ready0) begin
      iss0_d.valid = 1'b0;
    end
    iss1_d = iss1_q;
    if (fire1) begin
      iss1_d = '{valid: 1'b1, op: ent[rs_issue1].op, dst: ent[rs_issue1].dst,
                 a: ent[rs_issue1].s1.val, b: ent[rs_issue1].s2.val};
    end else if (fu_ready1) begin
      iss1_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss0_q <= '0;
      iss1_q <= '0;
    end else begin
      iss0_q <= iss0_d;
      iss1_q <= iss1_d;
    end
  end

  assign iss_valid0 = iss0_q.valid;
  assign iss_op0    = iss0_q.op;
  assign iss_dst0   = iss0_q.dst;
  assign iss_a0     = iss0_q.a;
  assign iss_b0     = iss0_q.b;
  assign iss_valid1 = iss1_q.valid;
  assign iss_op1    = iss1_q.op;
  assign iss_dst1   = iss1_q.dst;
  assign iss_a1     = iss1_q.a;
  assign iss_b1     = iss1_q.b;

endmodule

// File: doc/reservation_station.md
# reservation_station

Eight-entry reservation station for the dual-issue out-of-order core. It holds dispatched instructions until their source operands arrive, either at dispatch or from the two CDB broadcast lanes. It drives the per-entry `free_rs`/`rdy` vectors to the combinational allocate/issue unit. It consumes that unit's `rs_entry0/1`, `rs_issue0/1` and `rs_full` to place new instructions and to launch up to two ready instructions per cycle into registered issue ports.

## Interface
Parameters:
- `NUM_RS`, 8: entry count. Fixed by the allocator's 3-bit indices.
- `TAG_W`, 4: ROB/physical tag width.
- `DATA_W`, 32: operand width.
- `OP_W`, 4: opcode width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `rst_n`  in  1  asynchronous active-low reset.
- Dispatch (lane k = 0,1):
  - `disp_valid_k`  in  1  lane k carries an instruction.
  - `disp_op_k`  in  OP_W  opcode.
  - `disp_dst_k`  in  TAG_W  destination tag.
  - `disp_s1_tag_k`, `disp_s2_tag_k`  in  TAG_W  source tags.
  - `disp_s1_rdy_k`, `disp_s2_rdy_k`  in  1  source value already valid.
  - `disp_s1_val_k`, `disp_s2_val_k`  in  DATA_W  source values.
  - `disp_ready`  out  1  equals `~rs_full`. Dispatch is accepted only when high.
- Allocator handshake:
  - `rs_entry0`, `rs_entry1`  in  3  target slots for dispatch lanes 0 and 1.
  - `rs_issue0`, `rs_issue1`  in  3  slots selected for issue lanes 0 and 1.
  - `rs_full`  in  1  high when fewer than 2 entries are free.
  - `free_rs`  out  [0:7]  entry j not busy. Bit 0 is entry 0.
  - `rdy`  out  [0:7]  entry j busy and both sources ready.
- Result broadcast (lane c = 0,1):
  - `cdb_valid_c`  in  1  broadcast valid.
  - `cdb_tag_c`  in  TAG_W  producing tag.
  - `cdb_val_c`  in  DATA_W  result value.
- Functional units (lane k = 0,1):
  - `fu_ready_k`  in  1  functional unit k accepts an instruction this cycle.
  - `iss_valid_k`  out  1  issue register k holds an instruction.
  - `iss_op_k`  out  OP_W  opcode.
  - `iss_dst_k`  out  TAG_W  destination tag.
  - `iss_a_k`, `iss_b_k`  out  DATA_W  operand values.

## Operation
- Per-entry state:
  - `busy`, `op`, `dst`.
  - For each source: `tag`, `rdy`, `val`.
- Outputs:
  - `free_rs[j] = ~busy[j]`.
  - `rdy[j] = busy[j] & s1.rdy & s2.rdy`.
  - Both are purely registered state; there are no combinational paths from inputs.
- Dispatch:
  - When `disp_ready & disp_valid0`, lane 0 is written into entry `rs_entry0`.
  - When `disp_ready & disp_valid1`, lane 1 is written into entry `rs_entry1`.
  - `busy` is set at that edge.
  - When `rs_full` is high, both lanes are ignored. The upstream stage holds its instructions.
- Dispatch-time wakeup: a source arriving not ready whose tag matches a valid CDB lane in the same cycle is stored ready, with the CDB value. CDB lane 0 takes priority if both lanes match.
- CDB wakeup: every busy entry with a not-ready source whose tag equals a valid `cdb_tag_c` captures `cdb_val_c` and sets that source ready at the edge.
- Issue-slot qualification:
  - `n_rdy = popcount(rdy)`.
  - Issue lane 0 fires when `n_rdy>=1 & fu_ready0`.
  - Issue lane 1 fires when `n_rdy>=2 & fu_ready1`.
  - Indices from the allocator are used only when qualified, because the allocator drives z when it has no slot.
- A firing lane k loads `iss_*_k` from entry `rs_issue_k` and clears that entry's `busy`.
- A non-firing lane k with `fu_ready_k` high clears `iss_valid_k`. When `fu_ready_k` is low, the lane's `iss_*_k` registers hold.
- Entry capacity: 8 busy entries maximum. With 7 busy, `rs_full` is high, so one free entry stays unused until another entry frees.

## Timing
- Reset:
  - All `busy`=0, so `free_rs`=8'hFF and `rdy`=8'h00.
  - `iss_valid_k`=0. All issue data registers are 0.
  - `disp_ready` then follows `rs_full`, which the allocator drives low.
- Dispatch to `rdy`:
  - An instruction with both sources ready at dispatch shows `rdy` the next cycle.
  - It is in `iss_*` one cycle later. Minimum dispatch-to-issue-register latency is 2 cycles.
- CDB wakeup: a CDB broadcast at edge N makes `rdy` visible after N, so issue can happen at N+1.
- Freeing on issue: an issued entry's `free_rs` bit rises the cycle after issue. That entry cannot be re-targeted in its issue cycle.
- Collisions: dispatch and issue never target the same entry, because a free entry is never ready. No further collision handling is required.
- Reset asserted mid-operation clears all entries and issue registers immediately. Pending broadcasts are lost.

## Structure
- Shared package `rs_pkg`:
  - `NUM_RS`, `TAG_W`, `DATA_W`, `OP_W`.
  - Typedef `rs_src_t` (tag, rdy, val).
  - Typedef `rs_ent_t` (busy, op, dst, s1, s2).
- Sub-module `rs_slot`: one entry with its write port, dual-CDB tag compare/capture, and clear-on-issue. It is instantiated 8 times.
- The top level handles dispatch decode, issue mux/registers and the popcount qualification.

## Test plan
- Reset test: with `rst_n` low, check `free_rs`=8'hFF, `rdy`=0, `iss_valid0/1`=0. Assert `rst_n` low mid-run with 5 entries busy and confirm every output returns to its reset value.
- Two ready dispatches: dispatch two instructions with all sources ready into entries 0 and 1. Expect:
  - The next cycle: `rdy`=8'b1100_0000.
  - The cycle after: `iss_valid0/1`=1 with the correct operands.
  - Then `free_rs` is back to 8'hFF.
- CDB wakeup: dispatch an instruction with source 1 tag 4'h5 not ready. Broadcast tag 5, value 32'hDEAD_BEEF, on CDB lane 1 three cycles later. Expect `rdy` to rise the next cycle and `iss_a0`=32'hDEAD_BEEF.
- Same-cycle dispatch wakeup: dispatch a source with tag 4'h3 not ready while `cdb_valid0` carries tag 3 in the same cycle. Expect the entry to be ready the next cycle with the CDB value.
- Full handling: fill 7 entries with tags that are never broadcast. Expect `rs_full`=1 and `disp_ready`=0, and further dispatches are ignored with `free_rs` unchanged.
- Functional-unit backpressure: with 3 entries ready, hold `fu_ready1`=0. Expect only lane 0 to issue each cycle while `iss_*1` holds; entries drain 1 per cycle.
